// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM controller.
package ram_pkg;
  typedef enum logic {RAM_INIT, RAM_RUN} ram_state_t;

  localparam int READ_FIRST_MODE  = 1;
  localparam int WRITE_FIRST_MODE = 0;
endpackage

// File: rtl/sdp_ram_core.sv
// Bare storage array: one write port, one registered read port, no reset.
module sdp_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read samples the array before this edge's write, so collisions are read-first.
  always_ff @(posedge clk_2) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sdp_ram_ctrl.sv
// SDP RAM controller: zero-fill sweep after reset/clr_req, gated accesses,
// registered read with selectable collision behaviour.
module sdp_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_FIRST = 1
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  clr_req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  ready
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  ram_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
  logic                  run, acc, rd_fire;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_wdata, core_q;
  logic                  rd_zero, byp_sel;
  logic [DATA_WIDTH-1:0] byp_data;

  assign run     = (state == RAM_RUN);
  assign acc     = run & ~clr_req;
  assign rd_fire = acc & re;
  assign ready   = run;

  // The sweep owns the write port outside RUN.
  assign core_we    = ~run | (acc & we);
  assign core_waddr = run ? waddr : init_cnt;
  assign core_wdata = run ? wdata : '0;

  sdp_ram_core #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_core (
    .clk_2 (clk_2),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (rd_fire),
    .raddr (raddr),
    .rdata (core_q)
  );

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (!run) begin
      if (clr_req) begin
        init_cnt_nxt = '0;
      end else if (init_cnt == LAST) begin
        state_nxt    = RAM_RUN;
        init_cnt_nxt = '0;
      end else begin
        init_cnt_nxt = init_cnt + 1'b1;
      end
    end else if (clr_req) begin
      state_nxt    = RAM_INIT;
      init_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RAM_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The core register has no reset; rd_zero masks it until the first real read.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      rvalid   <= 1'b0;
      rd_zero  <= 1'b1;
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) begin
        rd_zero  <= 1'b0;
        byp_sel  <= (READ_FIRST == WRITE_FIRST_MODE) && we && (waddr == raddr);
        byp_data <= wdata;
      end
    end
  end

  assign rdata = rd_zero ? '0 : (byp_sel ? byp_data : core_q);
endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Randomised + directed bench for sdp_ram_ctrl against a behavioural memory model.
module tb_sdp_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, clr, we, re;
  logic [3:0] wa, ra;
  logic [7:0] wd;
  logic [7:0] rd_rf, rd_wf;
  logic       rv_rf, rv_wf, rdy_rf, rdy_wf;

  logic       s_rst, s_clr, s_we, s_re;
  logic [1:0] s_wa, s_ra;
  logic [3:0] s_wd, s_rd;
  logic       s_rv, s_rdy;

  int checks = 0;
  int errors = 0;

  int m_mem [16];
  int m_left;
  bit m_ready, m_rv;
  int m_rd_rf, m_rd_wf;

  always #5 clk = ~clk;

  sdp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_FIRST(1)) u_rf (
    .clk_2(clk), .reset_n(rst_n), .clr_req(clr), .we(we), .waddr(wa), .wdata(wd),
    .re(re), .raddr(ra), .rdata(rd_rf), .rvalid(rv_rf), .ready(rdy_rf));

  sdp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_FIRST(0)) u_wf (
    .clk_2(clk), .reset_n(rst_n), .clr_req(clr), .we(we), .waddr(wa), .wdata(wd),
    .re(re), .raddr(ra), .rdata(rd_wf), .rvalid(rv_wf), .ready(rdy_wf));

  sdp_ram_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .READ_FIRST(1)) u_sm (
    .clk_2(clk), .reset_n(s_rst), .clr_req(s_clr), .we(s_we), .waddr(s_wa), .wdata(s_wd),
    .re(s_re), .raddr(s_ra), .rdata(s_rd), .rvalid(s_rv), .ready(s_rdy));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_left = 16; m_rv = 0; m_rd_rf = 0; m_rd_wf = 0;
  endtask

  // Behaviour of one clock edge, from the pre-edge inputs.
  task automatic model_edge(bit c, bit w, int a, int d, bit r, int b);
    if (!m_ready) begin
      m_rv = 0;
      if (c) m_left = 16;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_ready = 1;
          foreach (m_mem[i]) m_mem[i] = 0;
        end
      end
    end else if (c) begin
      m_ready = 0; m_left = 16; m_rv = 0;
    end else begin
      m_rv = r;
      if (r) begin
        m_rd_rf = m_mem[b];
        m_rd_wf = (w && a == b) ? d : m_mem[b];
      end
      if (w) m_mem[a] = d;
    end
  endtask

  task automatic cycle(bit c, bit w, int a, int d, bit r, int b);
    clr = c; we = w; wa = 4'(a); wd = 8'(d); re = r; ra = 4'(b);
    @(posedge clk);
    model_edge(c, w, a, d, r, b);
    #1;
    check("ready_rf", rdy_rf, m_ready);
    check("ready_wf", rdy_wf, m_ready);
    check("rvalid_rf", rv_rf, m_rv);
    check("rvalid_wf", rv_wf, m_rv);
    check("rdata_rf", rd_rf, m_rd_rf);
    check("rdata_wf", rd_wf, m_rd_wf);
    clr = 0; we = 0; re = 0;
  endtask

  task automatic s_cycle(bit w, int a, int d, bit r, int b);
    s_we = w; s_wa = 2'(a); s_wd = 4'(d); s_re = r; s_ra = 2'(b);
    @(posedge clk); #1;
    s_we = 0; s_re = 0;
  endtask

  initial begin
    rst_n = 0; clr = 0; we = 0; re = 0; wa = 0; ra = 0; wd = 0;
    s_rst = 0; s_clr = 0; s_we = 0; s_re = 0; s_wa = 0; s_ra = 0; s_wd = 0;
    model_reset();
    #3;
    check("reset_ready", rdy_rf, 0);
    check("reset_rvalid", rv_rf, 0);
    check("reset_rdata", rd_rf, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Sweep: ready after exactly 16 edges; bad access at edge 5 is ignored.
    for (int i = 0; i < 16; i++) begin
      if (i == 4) cycle(0, 1, 2, 8'hFF, 1, 2);
      else        cycle(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1, i);

    // Basic write/read, then a one-idle hold of rdata.
    cycle(0, 1, 3, 8'hA5, 0, 0);
    cycle(0, 1, 15, 8'h3C, 0, 0);
    cycle(0, 0, 0, 0, 1, 3);
    cycle(0, 0, 0, 0, 1, 15);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 4);

    // Collision on address 7.
    cycle(0, 1, 7, 8'h11, 0, 0);
    cycle(0, 1, 7, 8'h22, 1, 7);
    cycle(0, 0, 0, 0, 1, 7);

    // Fill, then clear with a competing write that must be dropped.
    for (int i = 0; i < 16; i++) cycle(0, 1, i, i, 0, 0);
    cycle(0, 0, 0, 0, 1, 9);
    cycle(1, 1, 0, 8'h77, 1, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 9);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 50) == 0, $urandom % 2, $urandom % 16, $urandom % 256,
            $urandom % 2, $urandom % 16);

    // Clear requested again during the sweep restarts it.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 1, i % 16, 8'h5A, 1, i % 16);

    // Narrow instance: async reset mid-sweep and mid-read.
    s_rst = 1;
    s_cycle(0, 0, 0, 0, 0);
    s_cycle(0, 0, 0, 0, 0);
    #2 s_rst = 0; #1;
    check("sm_midsweep_ready", s_rdy, 0);
    check("sm_midsweep_rvalid", s_rv, 0);
    check("sm_midsweep_rdata", s_rd, 0);
    @(posedge clk); #1;
    s_rst = 1;
    for (int i = 0; i < 4; i++) s_cycle(0, 0, 0, 0, 0);
    check("sm_ready1", s_rdy, 1);
    s_cycle(1, 3, 4'h9, 0, 0);
    s_cycle(0, 0, 0, 1, 3);
    check("sm_read_rvalid", s_rv, 1);
    check("sm_read_rdata", s_rd, 4'h9);
    s_re = 1; s_ra = 3;
    #2 s_rst = 0; #1;
    check("sm_midread_rvalid", s_rv, 0);
    check("sm_midread_rdata", s_rd, 0);
    @(posedge clk); #1;
    s_re = 0; s_rst = 1;
    for (int i = 0; i < 4; i++) begin
      s_cycle(0, 0, 0, 0, 0);
      check("sm_ready_rise", s_rdy, (i == 3));
    end
    s_cycle(1, 3, 4'h9, 0, 0);
    s_cycle(0, 0, 0, 1, 3);
    check("sm_final_rvalid", s_rv, 1);
    check("sm_final_rdata", s_rd, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdp_ram_ctrl.md
Name: sdp_ram_ctrl

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one independent read port, with a registered read output and a read-valid strobe. A hardware init sequencer zeroes every word after reset or on request, and a ready flag gates all accesses. It replaces the single-port switch-driven memory as the generic storage block for board labs, with SWI/LED wiring left to top.

Parameters:
DATA_WIDTH, 8, bits per word.
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words (16).
READ_FIRST, 1, same-address read/write collision: 1 returns old word, 0 returns wdata (write-first).

Ports:
clk_2  input  1  single clock; all state changes on posedge.
reset_n  input  1  asynchronous active-low reset.
clr_req  input  1  restart the zero-fill sequence (sampled level, acts on the edge where it is high).
we  input  1  write enable.
waddr  input  ADDR_WIDTH  write address.
wdata  input  DATA_WIDTH  write data.
re  input  1  read enable.
raddr  input  ADDR_WIDTH  read address.
rdata  output  DATA_WIDTH  registered read data.
rvalid  output  1  one-cycle strobe: rdata was updated on the last edge.
ready  output  1  high when in RUN; accesses are accepted only while high.

Behaviour:
- Reset (reset_n=0, async): state=INIT, init_cnt=0, rdata=0, rvalid=0, ready=0. Array contents are not reset directly; the INIT sweep clears them.
- FSM states: INIT, RUN.
- INIT: on each edge, mem[init_cnt]<=0 and init_cnt++. On the edge where init_cnt==DEPTH-1, that word is cleared and state goes to RUN, with ready=1 after that edge. ready therefore rises exactly DEPTH edges after reset release. we and re are ignored in INIT, and rvalid stays 0.
- RUN, write: if we=1, mem[waddr]<=wdata on the edge.
- RUN, read: if re=1, rdata<=mem[raddr] on the edge and rvalid=1 for that cycle. Latency is 1 clock. If re=0, then rvalid=0 and rdata holds its last value.
- Collision (we&re, waddr==raddr, RUN): the write always happens. rdata gets the old word when READ_FIRST=1, or wdata when READ_FIRST=0.
- clr_req=1 in RUN: it takes priority over we and re in that cycle, which are both dropped. On that edge: state=INIT, init_cnt=0, ready=0, rvalid=0. rdata holds.
- clr_req=1 in INIT: init_cnt restarts at 0, so the full DEPTH-cycle sweep follows the last clr_req.
- Reset asserted mid-operation: immediate return to the reset values above. Any in-flight read is lost, with rvalid=0.
- Address width is exact, with no out-of-range case. init_cnt is ADDR_WIDTH bits, and the terminal compare is made before wrap.

Decomposition:
- Package ram_pkg: typedef enum logic {RAM_INIT, RAM_RUN} ram_state_t; constants READ_FIRST_MODE=1, WRITE_FIRST_MODE=0.
- Sub-module sdp_ram_core: a bare array with one write port (we, addr, data) and a registered read port. It has no reset and no collision logic. The controller muxes the init sweep onto its write port and resolves collisions.

Test Plan (defaults unless noted):
1. Release reset_n, idle -> ready=0 for 15 edges, ready=1 after the 16th. Then read all addresses 0..15 -> rdata=0x00 each time, each with a one-cycle rvalid.
2. In RUN, write 0xA5@3 and 0x3C@15, then read @3 and @15 -> rdata=0xA5 and 0x3C, one cycle after re. Read @4 -> 0x00.
3. Write 0x11@7; next cycle we=1 0x22@7 with re=1 @7. READ_FIRST=1 -> rdata=0x11; READ_FIRST=0 -> rdata=0x22. A following read @7 -> 0x22 in both modes.
4. Assert we/re while ready=0, e.g. write 0xFF@2 at cycle 5 after reset -> ignored and rvalid=0. Once ready, read @2 -> 0x00.
5. Fill 0x00..0x0F, pulse clr_req together with we=1 0x77@0 -> ready drops next edge and the write is dropped. ready returns after 16 edges. Then read @0 and @9 -> 0x00.
6. With DATA_WIDTH=4, ADDR_WIDTH=2: pulse reset_n low mid-sweep and mid-read -> rvalid=0 and rdata=0 immediately. ready rises after 4 edges, and a write/read of 0x9@3 returns 0x9.
